// File: rtl/formula_pipe_credit_adapter_if.sv
// ============================================================================
// formula_pipe_credit_adapter_if
// Bundles upstream, pipe-issue, pipe-result and downstream signals.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface formula_pipe_credit_adapter_if #(
   parameter int WIDTH = 32
);
   logic             up_vld;
   logic             up_rdy;
   logic [WIDTH-1:0] up_a;
   logic [WIDTH-1:0] up_b;
   logic [WIDTH-1:0] up_c;
   logic             arg_vld;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic             res_vld;
   logic [WIDTH-1:0] res;
   logic             down_vld;
   logic             down_rdy;
   logic [WIDTH-1:0] down_data;
   logic             err_ovf;

   // Adapter side
   modport slave (
      input  up_vld, up_a, up_b, up_c, res_vld, res, down_rdy,
      output up_rdy, arg_vld, a, b, c, down_vld, down_data, err_ovf
   );

   // Environment side (source, pipe and sink together)
   modport master (
      output up_vld, up_a, up_b, up_c, res_vld, res, down_rdy,
      input  up_rdy, arg_vld, a, b, c, down_vld, down_data, err_ovf
   );
endinterface

`default_nettype wire

// File: rtl/formula_pipe_credit_adapter.sv
// ============================================================================
// formula_pipe_credit_adapter
// Credit-limited issue to a fixed-latency pipe with a show-ahead result FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module formula_pipe_credit_adapter #(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 8
) (
   input wire clk,
   input wire rst,
   formula_pipe_credit_adapter_if.slave bus
);
   localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
   localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FIFO_DEPTH - 1);

   logic [c_cnt_w-1:0] credit_q, credit_d;
   logic [c_cnt_w-1:0] count_q, count_d;
   logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
   logic               arg_vld_q, arg_vld_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic               err_ovf_q, err_ovf_d;
   logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];

   logic w_up_rdy, w_down_vld, w_issue, w_pop, w_full, w_wr_en;

   always_comb begin
      w_up_rdy   = (credit_q != '0);
      w_down_vld = (count_q != '0);
      w_issue    = bus.up_vld & w_up_rdy;
      w_pop      = w_down_vld & bus.down_rdy;
      w_full     = (count_q == c_depth);
      // A pop in the same cycle frees the slot the incoming result lands in
      w_wr_en    = bus.res_vld & (~w_full | w_pop);

      credit_d  = credit_q - c_cnt_w'(w_issue) + c_cnt_w'(w_pop);
      count_d   = count_q + c_cnt_w'(w_wr_en) - c_cnt_w'(w_pop);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      arg_vld_d = w_issue;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      err_ovf_d = err_ovf_q | (bus.res_vld & w_full & ~w_pop);

      if (w_wr_en) begin
         wr_ptr_d = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
      end
      if (w_issue) begin
         a_d = bus.up_a;
         b_d = bus.up_b;
         c_d = bus.up_c;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_q  <= c_depth;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         arg_vld_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         err_ovf_q <= 1'b0;
      end else begin
         credit_q  <= credit_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         arg_vld_q <= arg_vld_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         err_ovf_q <= err_ovf_d;
      end
   end

   // Storage needs no reset: count_q gates every observable read
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         mem_q[wr_ptr_q] <= bus.res;
      end
   end

   assign bus.up_rdy    = w_up_rdy;
   assign bus.arg_vld   = arg_vld_q;
   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.c         = c_q;
   assign bus.down_vld  = w_down_vld;
   assign bus.down_data = mem_q[rd_ptr_q];
   assign bus.err_ovf   = err_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_formula_pipe_credit_adapter.sv
// ============================================================================
// tb_formula_pipe_credit_adapter
// Directed bench with a 4-deep a+b+c pipe model and result injection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_formula_pipe_credit_adapter;
   localparam int WIDTH = 32;
   localparam int DEPTH = 8;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   logic             inj_vld;
   logic [WIDTH-1:0] inj_data;
   logic [3:0]       pv;
   logic [WIDTH-1:0] pd [4];

   formula_pipe_credit_adapter_if #(.WIDTH(WIDTH)) bus ();

   formula_pipe_credit_adapter #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fixed-latency pipe model: arg_vld -> res_vld four cycles later
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pv <= '0;
         for (int i = 0; i < 4; i++) pd[i] <= '0;
      end else begin
         pv    <= {pv[2:0], bus.arg_vld};
         pd[0] <= bus.a + bus.b + bus.c;
         pd[1] <= pd[0];
         pd[2] <= pd[1];
         pd[3] <= pd[2];
      end
   end

   assign bus.res_vld = pv[3] | inj_vld;
   assign bus.res     = inj_vld ? inj_data : pd[3];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if (bus.up_rdy !== 1'b1) begin
         $display("FAIL reset_up_rdy: got %0b expected 1", bus.up_rdy);
      end else n_pass++;
      n_total++;
      if (bus.down_vld !== 1'b0) begin
         $display("FAIL reset_down_vld: got %0b expected 0", bus.down_vld);
      end else n_pass++;
      n_total++;
      if (bus.arg_vld !== 1'b0) begin
         $display("FAIL reset_arg_vld: got %0b expected 0", bus.arg_vld);
      end else n_pass++;
      n_total++;
      if (bus.err_ovf !== 1'b0) begin
         $display("FAIL reset_err_ovf: got %0b expected 0", bus.err_ovf);
      end else n_pass++;
      n_total++;
      step();
   endtask

   task automatic test_single();
      bus.up_vld = 1'b1;
      bus.up_a = 1; bus.up_b = 2; bus.up_c = 3;
      if (bus.up_rdy !== 1'b1) begin
         $display("FAIL single_up_rdy: got %0b expected 1", bus.up_rdy);
      end else n_pass++;
      n_total++;
      step();                                    // cycle 1
      bus.up_vld = 1'b0;
      bus.up_a = 7; bus.up_b = 7; bus.up_c = 7;
      if (bus.arg_vld !== 1'b1 || bus.a !== 1 || bus.b !== 2 || bus.c !== 3) begin
         $display("FAIL single_issue: got vld=%0b a/b/c=%0d/%0d/%0d expected vld=1 a/b/c=1/2/3",
                  bus.arg_vld, bus.a, bus.b, bus.c);
      end else n_pass++;
      n_total++;
      step();                                    // cycle 2
      if (bus.arg_vld !== 1'b0 || bus.a !== 1) begin
         $display("FAIL single_hold: got vld=%0b a=%0d expected vld=0 a=1", bus.arg_vld, bus.a);
      end else n_pass++;
      n_total++;
      repeat (3) step();                         // cycle 5
      if (bus.down_vld !== 1'b0) begin
         $display("FAIL single_early: got down_vld=%0b expected 0", bus.down_vld);
      end else n_pass++;
      n_total++;
      step();                                    // cycle 6
      if (bus.down_vld !== 1'b1 || bus.down_data !== 6) begin
         $display("FAIL single_result: got vld=%0b data=%0d expected vld=1 data=6",
                  bus.down_vld, bus.down_data);
      end else n_pass++;
      n_total++;
      bus.down_rdy = 1'b1;
      step();
      bus.down_rdy = 1'b0;
      if (bus.down_vld !== 1'b0) begin
         $display("FAIL single_popped: got down_vld=%0b expected 0", bus.down_vld);
      end else n_pass++;
      n_total++;
   endtask

   task automatic test_back_to_back();
      int exp_n;
      exp_n = 0;
      bus.down_rdy = 1'b1;
      for (int i = 0; i < 200; i++) begin
         bus.up_vld = 1'b1;
         bus.up_a = WIDTH'(i);
         bus.up_b = WIDTH'(2 * i);
         bus.up_c = '0;
         if (bus.up_rdy !== 1'b1) begin
            $display("FAIL b2b_up_rdy: cycle %0d got %0b expected 1", i, bus.up_rdy);
         end else n_pass++;
         n_total++;
         if (bus.down_vld === 1'b1) begin
            if (bus.down_data !== WIDTH'(3 * exp_n)) begin
               $display("FAIL b2b_data: result %0d got %0d expected %0d",
                        exp_n, bus.down_data, 3 * exp_n);
            end else n_pass++;
            n_total++;
            exp_n++;
         end
         step();
      end
      bus.up_vld = 1'b0;
      for (int k = 0; k < 40 && exp_n < 200; k++) begin
         if (bus.down_vld === 1'b1) begin
            if (bus.down_data !== WIDTH'(3 * exp_n)) begin
               $display("FAIL b2b_data: result %0d got %0d expected %0d",
                        exp_n, bus.down_data, 3 * exp_n);
            end else n_pass++;
            n_total++;
            exp_n++;
         end
         step();
      end
      if (exp_n !== 200) begin
         $display("FAIL b2b_count: got %0d results expected 200", exp_n);
      end else n_pass++;
      n_total++;
      if (bus.err_ovf !== 1'b0) begin
         $display("FAIL b2b_err_ovf: got %0b expected 0", bus.err_ovf);
      end else n_pass++;
      n_total++;
      bus.down_rdy = 1'b0;
      step();
   endtask

   task automatic test_credit_stall();
      int n;
      bit seen;
      n = 0;
      seen = 0;
      bus.down_rdy = 1'b0;
      bus.up_vld = 1'b1;
      bus.up_a = 10; bus.up_b = 1; bus.up_c = 2;
      for (int k = 0; k < 20; k++) begin
         if (bus.up_rdy === 1'b1) n++;
         step();
         if (n == 8 && !seen) begin
            seen = 1;
            if (bus.up_rdy !== 1'b0) begin
               $display("FAIL stall_up_rdy: got %0b expected 0 after 8th accept", bus.up_rdy);
            end else n_pass++;
            n_total++;
         end
         bus.up_a = WIDTH'(10 + n);
      end
      bus.up_vld = 1'b0;
      if (n !== 8) begin
         $display("FAIL stall_accepted: got %0d expected 8", n);
      end else n_pass++;
      n_total++;
      bus.down_rdy = 1'b1;
      if (bus.up_rdy !== 1'b0) begin
         $display("FAIL stall_before_pop: got up_rdy=%0b expected 0", bus.up_rdy);
      end else n_pass++;
      n_total++;
      for (int k = 0; k < 8; k++) begin
         if (bus.down_vld !== 1'b1 || bus.down_data !== WIDTH'(13 + k)) begin
            $display("FAIL stall_drain: entry %0d got vld=%0b data=%0d expected vld=1 data=%0d",
                     k, bus.down_vld, bus.down_data, 13 + k);
         end else n_pass++;
         n_total++;
         step();
         if (k == 0) begin
            if (bus.up_rdy !== 1'b1) begin
               $display("FAIL stall_credit_back: got up_rdy=%0b expected 1", bus.up_rdy);
            end else n_pass++;
            n_total++;
         end
      end
      if (bus.down_vld !== 1'b0) begin
         $display("FAIL stall_empty: got down_vld=%0b expected 0", bus.down_vld);
      end else n_pass++;
      n_total++;
      bus.down_rdy = 1'b0;
   endtask

   task automatic test_overflow();
      int n;
      n = 0;
      bus.down_rdy = 1'b0;
      bus.up_vld = 1'b1;
      bus.up_a = 20; bus.up_b = 1; bus.up_c = 2;
      for (int k = 0; k < 20; k++) begin
         if (bus.up_rdy === 1'b1) n++;
         step();
         bus.up_a = WIDTH'(20 + n);
      end
      bus.up_vld = 1'b0;
      if (n !== 8 || bus.err_ovf !== 1'b0) begin
         $display("FAIL ovf_fill: got accepted=%0d err=%0b expected accepted=8 err=0", n, bus.err_ovf);
      end else n_pass++;
      n_total++;
      inj_data = 32'h0000_DEAD;
      inj_vld = 1'b1;
      step();
      inj_vld = 1'b0;
      if (bus.err_ovf !== 1'b1) begin
         $display("FAIL ovf_set: got err_ovf=%0b expected 1", bus.err_ovf);
      end else n_pass++;
      n_total++;
      repeat (3) step();
      if (bus.err_ovf !== 1'b1) begin
         $display("FAIL ovf_sticky: got err_ovf=%0b expected 1", bus.err_ovf);
      end else n_pass++;
      n_total++;
      bus.down_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (bus.down_vld !== 1'b1 || bus.down_data !== WIDTH'(23 + k)) begin
            $display("FAIL ovf_contents: entry %0d got vld=%0b data=%0h expected vld=1 data=%0h",
                     k, bus.down_vld, bus.down_data, 23 + k);
         end else n_pass++;
         n_total++;
         step();
      end
      if (bus.down_vld !== 1'b0 || bus.err_ovf !== 1'b1) begin
         $display("FAIL ovf_after_drain: got vld=%0b err=%0b expected vld=0 err=1",
                  bus.down_vld, bus.err_ovf);
      end else n_pass++;
      n_total++;
      bus.down_rdy = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      int n;
      bus.down_rdy = 1'b0;
      bus.up_vld = 1'b1;
      bus.up_b = 0; bus.up_c = 0;
      for (int k = 0; k < 5; k++) begin
         bus.up_a = WIDTH'(30 + k);
         step();
      end
      bus.up_vld = 1'b0;
      repeat (3) step();
      if (bus.down_vld !== 1'b1 || bus.down_data !== 30) begin
         $display("FAIL mid_stored: got vld=%0b data=%0d expected vld=1 data=30",
                  bus.down_vld, bus.down_data);
      end else n_pass++;
      n_total++;
      rst = 1'b0;
      #1;
      if (bus.up_rdy !== 1'b1 || bus.down_vld !== 1'b0 || bus.arg_vld !== 1'b0 ||
          bus.err_ovf !== 1'b0 || bus.a !== 0) begin
         $display("FAIL mid_async: got rdy=%0b dvld=%0b avld=%0b err=%0b a=%0d expected 1/0/0/0/0",
                  bus.up_rdy, bus.down_vld, bus.arg_vld, bus.err_ovf, bus.a);
      end else n_pass++;
      n_total++;
      step();
      step();
      rst = 1'b1;
      repeat (8) step();
      if (bus.down_vld !== 1'b0) begin
         $display("FAIL mid_flushed: got down_vld=%0b expected 0", bus.down_vld);
      end else n_pass++;
      n_total++;
      n = 0;
      bus.up_vld = 1'b1;
      for (int k = 0; k < 14; k++) begin
         if (bus.up_rdy === 1'b1) n++;
         step();
      end
      bus.up_vld = 1'b0;
      if (n !== 8) begin
         $display("FAIL mid_credit: got %0d accepts expected 8", n);
      end else n_pass++;
      n_total++;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rst = 1'b0;
      inj_vld = 1'b0;
      inj_data = '0;
      bus.up_vld = 1'b0;
      bus.up_a = '0;
      bus.up_b = '0;
      bus.up_c = '0;
      bus.down_rdy = 1'b0;
      repeat (2) step();
      test_reset();
      test_single();
      test_back_to_back();
      test_credit_stall();
      test_overflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
